// File: rtl/bus_ctl_pkg.sv
// Shared types for the 68000 bus-cycle sequencer: FSM states, decoded regions, counter widths.
// Region priority is fixed here so every user of the decoder selects agrees on it.
package bus_ctl_pkg;

  localparam int WAIT_CNT_W = 4;
  localparam int TMO_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } bus_state_t;

  typedef enum logic [2:0] {
    RGN_ROM,
    RGN_RAM,
    RGN_IO,
    RGN_EXP,
    RGN_UNMAPPED
  } region_t;

  function automatic region_t decode_region(input logic rom_n, input logic ram_n,
                                            input logic io_n, input logic exp_n);
    if (!rom_n)      return RGN_ROM;
    else if (!ram_n) return RGN_RAM;
    else if (!io_n)  return RGN_IO;
    else if (!exp_n) return RGN_EXP;
    else             return RGN_UNMAPPED;
  endfunction

  // Regions whose acknowledge comes from the local wait-state count.
  function automatic logic is_counted(input region_t r);
    return (r == RGN_ROM) || (r == RGN_RAM) || (r == RGN_IO);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter for bus wait states; load has priority over enable, stops at zero.
// zero/last are combinational views of the current count (last = one step from zero).
module wait_counter
  import bus_ctl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  en,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  zero,
  output logic                  last
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == WAIT_CNT_W'(1));

endmodule

// File: rtl/dtack_controller.sv
// 68000 bus-cycle sequencer: per-region wait states, DTACK/BERR generation, boot overlay flag.
// DTACK after edge k+1+WS; BERR after edge k+TIMEOUT; strobes release on the edge sampling AS_n high.
module dtack_controller
  import bus_ctl_pkg::*;
#(
  parameter int ROM_WS      = 2,
  parameter int RAM_WS      = 0,
  parameter int IO_WS       = 3,
  parameter int TIMEOUT     = 64,
  parameter int BOOT_CYCLES = 4
) (
  input  logic i_CLK,
  input  logic i_RESET_n,
  input  logic i_AS_n,
  input  logic i_ROMSEL_n,
  input  logic i_RAMSEL_n,
  input  logic i_IOSEL_n,
  input  logic i_EXPSEL_n,
  input  logic i_EXPDTACK_n,
  output logic o_DTACK_n,
  output logic o_BERR_n,
  output logic o_BOOT,
  output logic o_TIMEOUT
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam logic [WAIT_CNT_W-1:0] ROM_WS_V = WAIT_CNT_W'(ROM_WS);
  localparam logic [WAIT_CNT_W-1:0] RAM_WS_V = WAIT_CNT_W'(RAM_WS);
  localparam logic [WAIT_CNT_W-1:0] IO_WS_V  = WAIT_CNT_W'(IO_WS);
  localparam logic [TMO_CNT_W-1:0]  TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
  localparam logic [BOOT_W-1:0]     BOOT_MAX = BOOT_W'(BOOT_CYCLES);

  bus_state_t state, state_d;
  region_t    region, region_d, req_region;

  logic [WAIT_CNT_W-1:0] req_ws;
  logic [TMO_CNT_W-1:0]  tmo_cnt, tmo_d;
  logic [BOOT_W-1:0]     boot_cnt, boot_d;
  logic                  wc_load, wc_en, wc_zero, wc_last;
  logic                  ack_hit;
  logic                  dtack_d, berr_d;

  assign req_region = decode_region(i_ROMSEL_n, i_RAMSEL_n, i_IOSEL_n, i_EXPSEL_n);

  always_comb begin
    req_ws = '0;
    case (req_region)
      RGN_ROM: req_ws = ROM_WS_V;
      RGN_RAM: req_ws = RAM_WS_V;
      RGN_IO:  req_ws = IO_WS_V;
      default: req_ws = '0;
    endcase
  end

  wait_counter u_wait_counter (
    .clk      (i_CLK),
    .rst_n    (i_RESET_n),
    .load     (wc_load),
    .en       (wc_en),
    .load_val (req_ws),
    .zero     (wc_zero),
    .last     (wc_last)
  );

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state    <= ST_IDLE;
      region   <= RGN_UNMAPPED;
      tmo_cnt  <= '0;
      boot_cnt <= '0;
    end else begin
      state    <= state_d;
      region   <= region_d;
      tmo_cnt  <= tmo_d;
      boot_cnt <= boot_d;
    end
  end

  always_comb begin
    state_d  = state;
    region_d = region;
    tmo_d    = tmo_cnt;
    boot_d   = boot_cnt;
    wc_load  = 1'b0;
    wc_en    = 1'b0;
    ack_hit  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!i_AS_n) begin
          region_d = req_region;
          wc_load  = 1'b1;
          tmo_d    = '0;
          if (is_counted(req_region) && (req_ws == '0)) state_d = ST_ACK;
          else                                          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (i_AS_n) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
          wc_en = is_counted(region);
          // Counted regions acknowledge on the edge the count reaches zero.
          if (is_counted(region))      ack_hit = wc_last || wc_zero;
          else if (region == RGN_EXP)  ack_hit = !i_EXPDTACK_n;
          if (ack_hit)                 state_d = ST_ACK;
          else if (tmo_d == TMO_LAST)  state_d = ST_BERR;
        end
      end

      ST_ACK: begin
        if (i_AS_n) begin
          state_d = ST_IDLE;
          if ((region == RGN_ROM) && (boot_cnt != BOOT_MAX)) boot_d = boot_cnt + 1'b1;
        end
      end

      ST_BERR: begin
        if (i_AS_n) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the current state so they drop on the same edge that sees AS_n high.
  assign dtack_d = (state == ST_ACK)  && !i_AS_n;
  assign berr_d  = (state == ST_BERR) && !i_AS_n;

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      o_DTACK_n <= 1'b1;
      o_BERR_n  <= 1'b1;
      o_BOOT    <= 1'b0;
      o_TIMEOUT <= 1'b0;
    end else begin
      o_DTACK_n <= !dtack_d;
      o_BERR_n  <= !berr_d;
      o_BOOT    <= o_BOOT || (boot_d == BOOT_MAX);
      o_TIMEOUT <= o_TIMEOUT || berr_d;
    end
  end

endmodule

// File: tb/tb_dtack_controller.sv
// Directed bench for dtack_controller: wait-state latency, boot flag, EXP handshake, timeout, abort, reset.
module tb_dtack_controller;

  localparam int ROM_WS      = 2;
  localparam int RAM_WS      = 0;
  localparam int IO_WS       = 3;
  localparam int TIMEOUT     = 64;
  localparam int BOOT_CYCLES = 4;

  localparam logic [3:0] SEL_NONE = 4'b1111;
  localparam logic [3:0] SEL_ROM  = 4'b1110;
  localparam logic [3:0] SEL_RAM  = 4'b1101;
  localparam logic [3:0] SEL_IO   = 4'b1011;
  localparam logic [3:0] SEL_EXP  = 4'b0111;

  logic clk = 1'b0;
  logic rst_n, as_n, romsel_n, ramsel_n, iosel_n, expsel_n, expdtack_n;
  logic dtack_n, berr_n, boot, timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dtack_controller #(
    .ROM_WS      (ROM_WS),
    .RAM_WS      (RAM_WS),
    .IO_WS       (IO_WS),
    .TIMEOUT     (TIMEOUT),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .i_CLK        (clk),
    .i_RESET_n    (rst_n),
    .i_AS_n       (as_n),
    .i_ROMSEL_n   (romsel_n),
    .i_RAMSEL_n   (ramsel_n),
    .i_IOSEL_n    (iosel_n),
    .i_EXPSEL_n   (expsel_n),
    .i_EXPDTACK_n (expdtack_n),
    .o_DTACK_n    (dtack_n),
    .o_BERR_n     (berr_n),
    .o_BOOT       (boot),
    .o_TIMEOUT    (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_sel(input logic [3:0] sel_n);
    {expsel_n, iosel_n, ramsel_n, romsel_n} = sel_n;
  endtask

  // Starts a cycle so the next edge is k; DTACK must be high after edge k+ws and low after k+ws+1.
  task automatic acked_cycle(input string tag, input logic [3:0] sel_n, input int ws,
                             input logic boot_exp);
    as_n = 1'b0;
    drive_sel(sel_n);
    step(ws + 1);
    check({tag, "_early"}, dtack_n, 1'b1);
    step(1);
    check({tag, "_dtack"}, dtack_n, 1'b0);
    check({tag, "_berr"}, berr_n, 1'b1);
    as_n = 1'b1;
    drive_sel(SEL_NONE);
    step(1);
    check({tag, "_release"}, dtack_n, 1'b1);
    check({tag, "_boot"}, boot, boot_exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    as_n       = 1'b1;
    expdtack_n = 1'b1;
    drive_sel(SEL_NONE);
    step(3);
    check("rst_dtack", dtack_n, 1'b1);
    check("rst_berr", berr_n, 1'b1);
    check("rst_boot", boot, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Vector fetch: BOOT flips after the 4th ROM release and stays set.
    for (int i = 1; i <= 5; i++)
      acked_cycle($sformatf("rom%0d", i), SEL_ROM, ROM_WS, i >= BOOT_CYCLES);

    // ROM wins over RAM when both are selected.
    acked_cycle("prio", 4'b1100, ROM_WS, 1'b1);

    // Zero wait states, back to back with no idle edge between.
    acked_cycle("ram1", SEL_RAM, RAM_WS, 1'b1);
    acked_cycle("ram2", SEL_RAM, RAM_WS, 1'b1);

    // Expansion acknowledge sampled at k+10.
    as_n = 1'b0;
    drive_sel(SEL_EXP);
    step(10);
    check("exp_pre", dtack_n, 1'b1);
    expdtack_n = 1'b0;
    step(1);
    check("exp_sampled", dtack_n, 1'b1);
    step(1);
    check("exp_dtack", dtack_n, 1'b0);
    check("exp_berr", berr_n, 1'b1);
    as_n       = 1'b1;
    expdtack_n = 1'b1;
    drive_sel(SEL_NONE);
    step(1);
    check("exp_release", dtack_n, 1'b1);

    // Expansion acknowledge on the very edge the timeout would fire: acknowledge wins.
    as_n = 1'b0;
    drive_sel(SEL_EXP);
    step(TIMEOUT - 1);
    check("exptmo_pre_berr", berr_n, 1'b1);
    expdtack_n = 1'b0;
    step(2);
    check("exptmo_dtack", dtack_n, 1'b0);
    check("exptmo_berr", berr_n, 1'b1);
    check("exptmo_flag", timeout, 1'b0);
    as_n       = 1'b1;
    expdtack_n = 1'b1;
    drive_sel(SEL_NONE);
    step(1);
    check("exptmo_release", dtack_n, 1'b1);

    // Unmapped access: BERR after edge k+TIMEOUT, not before.
    as_n = 1'b0;
    step(TIMEOUT);
    check("unmap_pre_berr", berr_n, 1'b1);
    check("unmap_pre_flag", timeout, 1'b0);
    step(1);
    check("unmap_berr", berr_n, 1'b0);
    check("unmap_flag", timeout, 1'b1);
    check("unmap_dtack", dtack_n, 1'b1);
    step(2);
    check("unmap_hold", berr_n, 1'b0);
    as_n = 1'b1;
    step(1);
    check("unmap_release", berr_n, 1'b1);
    check("unmap_sticky", timeout, 1'b1);

    // IO cycle aborted at k+2: no strobe at all.
    as_n = 1'b0;
    drive_sel(SEL_IO);
    step(2);
    as_n = 1'b1;
    drive_sel(SEL_NONE);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check($sformatf("abort_dtack%0d", i), dtack_n, 1'b1);
      check($sformatf("abort_berr%0d", i), berr_n, 1'b1);
    end
    acked_cycle("io", SEL_IO, IO_WS, 1'b1);

    // Reset during ACK clears outputs asynchronously and re-arms the boot overlay.
    as_n = 1'b0;
    drive_sel(SEL_ROM);
    step(ROM_WS + 2);
    check("rstack_dtack_before", dtack_n, 1'b0);
    check("rstack_boot_before", boot, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstack_dtack", dtack_n, 1'b1);
    check("rstack_boot", boot, 1'b0);
    check("rstack_flag", timeout, 1'b0);
    as_n = 1'b1;
    drive_sel(SEL_NONE);
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int i = 1; i <= BOOT_CYCLES; i++)
      acked_cycle($sformatf("reboot%0d", i), SEL_ROM, ROM_WS, i >= BOOT_CYCLES);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/dtack_controller.md
# dtack_controller

Bus-cycle sequencer for the 68000 memory map: sits beside the address decoder and consumes its chip-select outputs plus the CPU strobes. It inserts a per-region number of wait states and drives DTACK. It also raises BERR on unanswered or unmapped cycles. It owns the BOOT flag that the decoder uses to overlay ROM at address 0 for the reset vector fetch.

## Interface
Parameters:
- ROM_WS, 2, wait states for ROM cycles (0..15)
- RAM_WS, 0, wait states for RAM cycles (0..15)
- IO_WS, 3, wait states for IO cycles (0..15)
- TIMEOUT, 64, clocks from AS assertion to BERR (16..255)
- BOOT_CYCLES, 4, acknowledged ROM cycles before BOOT sets (vector fetch: SSP + PC words)

Ports:
- i_CLK  in  1  CPU clock; all logic on rising edge
- i_RESET_n  in  1  asynchronous active-low reset
- i_AS_n  in  1  CPU address strobe, synchronous to i_CLK
- i_ROMSEL_n  in  1  decoder ROM select (even or odd ROM active)
- i_RAMSEL_n  in  1  decoder RAM select (even or odd RAM active)
- i_IOSEL_n  in  1  decoder IO select
- i_EXPSEL_n  in  1  decoder expansion select
- i_EXPDTACK_n  in  1  DTACK from expansion device
- o_DTACK_n  out  1  registered DTACK to CPU
- o_BERR_n  out  1  registered bus error to CPU
- o_BOOT  out  1  0 = boot overlay active; 1 = normal map; feeds decoder i_BOOT
- o_TIMEOUT  out  1  sticky flag: a BERR has occurred since reset

## Operation
- States: IDLE, WAIT, ACK, BERR.
- IDLE: on AS_n sampled low, latch region by priority ROM > RAM > IO > EXP; no select = UNMAPPED. Load wait counter with the region's WS; clear timeout counter.
  - Counted region with WS = 0 -> ACK.
  - Otherwise -> WAIT.
- WAIT: counted regions decrement the wait counter; at 0 -> ACK. EXP ignores the counter and goes -> ACK on i_EXPDTACK_n sampled low. UNMAPPED never acknowledges. The timeout counter increments every cycle in WAIT; on reaching TIMEOUT-1 -> BERR.
- Simultaneous ACK condition and timeout in the same cycle: ACK wins.
- AS_n high while in WAIT (aborted cycle): -> IDLE; no DTACK, no BERR, no boot count.
- ACK: o_DTACK_n = 0; held until AS_n sampled high, then -> IDLE.
- BERR: o_BERR_n = 0; o_TIMEOUT set; held until AS_n sampled high, then -> IDLE.
- Boot counter increments on each ACK -> IDLE exit whose region is ROM, saturating at BOOT_CYCLES. o_BOOT goes 1 on the edge that the count reaches BOOT_CYCLES and stays 1 until reset.
- Reset values: state IDLE, o_DTACK_n = 1, o_BERR_n = 1, o_BOOT = 0, o_TIMEOUT = 0, all counters 0.
- Reset asserted mid-cycle: outputs take reset values immediately (asynchronous). The boot overlay is re-armed.
- Widths: wait counter 4 bits; timeout counter 8 bits; boot counter $clog2(BOOT_CYCLES+1) bits. No wrap: the wait counter stops at 0, the timeout counter is bounded by the transition to BERR, and the boot counter saturates.

## Timing
- AS_n sampled low at edge k, counted region, WS = n: o_DTACK_n low after edge k+1+n.
- EXP: o_DTACK_n low one edge after i_EXPDTACK_n is sampled low.
- Timeout: o_BERR_n low after edge k+TIMEOUT when no acknowledgement occurs.
- o_DTACK_n / o_BERR_n high after the edge that samples AS_n high; IDLE is re-entered on that same edge.
- Back-to-back cycles: AS_n low again on the edge after release is accepted, so there are no dead cycles.
- All outputs are flop outputs; no combinational path from inputs to outputs.

## Structure
- Shared package bus_ctl_pkg:
  - state encoding: IDLE, WAIT, ACK, BERR
  - region encoding: ROM, RAM, IO, EXP, UNMAPPED
  - counter width constants
- Sub-module wait_counter: a 4-bit loadable down-counter with load, enable and zero outputs, instantiated once for wait states.
- The timeout and boot counters stay inline.

## Test plan
- Reset, then 4 ROM reads (ROMSEL_n = 0, ROM_WS = 2) -> each DTACK low at k+3; o_BOOT rises after the 4th AS release; a 5th ROM read leaves o_BOOT = 1.
- RAM read with RAM_WS = 0, immediately followed by a second RAM read -> DTACK at k+1 for both; no idle cycle between them.
- EXP cycle with i_EXPDTACK_n low 10 clocks after AS -> DTACK on the following edge; o_BERR_n stays 1.
- AS low with no select, TIMEOUT = 64 -> o_BERR_n low at k+64; o_TIMEOUT = 1; both release on AS high, and o_TIMEOUT stays 1.
- EXP cycle with i_EXPDTACK_n asserted exactly on the timeout cycle -> DTACK, no BERR. Separately, AS released during IO WAIT (IO_WS = 3, release at k+2) -> neither strobe asserts.
- i_RESET_n pulsed low during ACK -> o_DTACK_n high immediately, o_BOOT = 0; the next ROM read is counted as boot cycle 1.
